// File: rtl/step_onehot_monitor_pkg.sv
// Shared definitions for the one-hot step monitor: state encoding,
// fault cause codes and default geometry of the step vector.
package step_onehot_monitor_pkg;

   // Default geometry: bit 0 is the start code, bits 1..8 the running cycle.
   localparam int N_STEPS_DEF = 9;
   localparam int IDX_W_DEF   = 4;
   localparam int RND_W_DEF   = 8;

   // Monitor state encoding.
   typedef enum logic [1:0] {
      INIT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   // Cause of the first fault, held until cleared.
   localparam logic [1:0] ERR_NONE       = 2'b00;
   localparam logic [1:0] ERR_NOT_ONEHOT = 2'b01;
   localparam logic [1:0] ERR_ORDER      = 2'b10;
   localparam logic [1:0] ERR_RESTART    = 2'b11;

endpackage

// File: rtl/step_onehot_monitor_if.sv
// Bundle of the step vector, clear request and monitor results.
// master: the side that drives the step vector and reads results.
// slave : the monitor itself.
interface step_onehot_monitor_if
   import step_onehot_monitor_pkg::*;
#(
   parameter int N_STEPS = N_STEPS_DEF,
   parameter int IDX_W   = IDX_W_DEF,
   parameter int RND_W   = RND_W_DEF
);
   logic [N_STEPS-1:0] step_in;
   logic               clr_err;
   logic [IDX_W-1:0]   idx;
   logic               idx_valid;
   logic               round_done;
   logic [RND_W-1:0]   round_cnt;
   logic               err;
   logic [1:0]         err_code;

   modport master (
      output step_in, clr_err,
      input  idx, idx_valid, round_done, round_cnt, err, err_code
   );

   modport slave (
      input  step_in, clr_err,
      output idx, idx_valid, round_done, round_cnt, err, err_code
   );
endinterface

// File: rtl/step_onehot_monitor_onehot_to_index.sv
// Combinational one-hot encoder: reports whether exactly one bit is set
// and the binary position of the set bit. Reusable for any one-hot bus.
module onehot_to_index #(
   parameter int N = 9,
   parameter int W = 4
) (
   input  logic [N-1:0] vec_i,
   output logic [W-1:0] pos_o,
   output logic         onehot_o
);

   // Classify the vector and encode the position of its set bit.
   always_comb begin
      pos_o    = '0;
      onehot_o = (vec_i != '0) && ((vec_i & (vec_i - N'(1))) == '0);
      for (int i = 0; i < N; i++) begin
         pos_o = pos_o | (vec_i[i] ? W'(i) : W'(0));
      end
   end

endmodule

// File: rtl/step_onehot_monitor.sv
// Receive-side checker for the one-hot step sequencer. Tracks the expected
// step order, reports the binary index, counts completed rounds and latches
// the first fault with its cause until cleared.
module step_onehot_monitor
   import step_onehot_monitor_pkg::*;
#(
   parameter int N_STEPS = N_STEPS_DEF,
   parameter int IDX_W   = IDX_W_DEF,
   parameter int RND_W   = RND_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   step_onehot_monitor_if.slave  bus
);

   state_t             state_q;
   logic [IDX_W-1:0]   prev_q;
   logic [IDX_W-1:0]   idx_q;
   logic               idx_valid_q;
   logic               round_done_q;
   logic [RND_W-1:0]   round_cnt_q;
   logic               err_q;
   logic [1:0]         err_code_q;

   logic [IDX_W-1:0]   pos_s;
   logic               onehot_s;
   logic [IDX_W-1:0]   exp_pos_s;

   onehot_to_index #(
      .N (N_STEPS),
      .W (IDX_W)
   ) u_enc (
      .vec_i    (bus.step_in),
      .pos_o    (pos_s),
      .onehot_o (onehot_s)
   );

   // Next legal step after prev: bit 1 after the start code or the last bit.
   always_comb begin
      if ((prev_q == IDX_W'(0)) || (prev_q == IDX_W'(N_STEPS - 1))) begin
         exp_pos_s = IDX_W'(1);
      end else begin
         exp_pos_s = prev_q + IDX_W'(1);
      end
   end

   // Monitor FSM with order tracking, round counting and sticky fault capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= INIT;
         prev_q       <= '0;
         idx_q        <= '0;
         idx_valid_q  <= 1'b0;
         round_done_q <= 1'b0;
         round_cnt_q  <= '0;
         err_q        <= 1'b0;
         err_code_q   <= ERR_NONE;
      end else begin
         round_done_q <= 1'b0;
         case (state_q)
            INIT: begin
               // A clear request is meaningless here; the step is judged as usual.
               if (onehot_s && (pos_s == IDX_W'(0))) begin
                  idx_q       <= '0;
                  idx_valid_q <= 1'b0;
               end else if (onehot_s && (pos_s == IDX_W'(1))) begin
                  state_q     <= RUN;
                  idx_q       <= IDX_W'(1);
                  idx_valid_q <= 1'b1;
                  prev_q      <= IDX_W'(1);
               end else if (!onehot_s) begin
                  state_q     <= FAULT;
                  idx_valid_q <= 1'b0;
                  err_q       <= 1'b1;
                  err_code_q  <= ERR_NOT_ONEHOT;
               end else begin
                  state_q     <= FAULT;
                  idx_valid_q <= 1'b0;
                  err_q       <= 1'b1;
                  err_code_q  <= ERR_ORDER;
               end
            end
            RUN: begin
               if (bus.clr_err) begin
                  // Forced re-sync: the sequencer must be seen starting again.
                  state_q     <= INIT;
                  idx_valid_q <= 1'b0;
                  prev_q      <= '0;
               end else if (!onehot_s) begin
                  state_q     <= FAULT;
                  idx_valid_q <= 1'b0;
                  err_q       <= 1'b1;
                  err_code_q  <= ERR_NOT_ONEHOT;
               end else if (pos_s == IDX_W'(0)) begin
                  state_q     <= FAULT;
                  idx_valid_q <= 1'b0;
                  err_q       <= 1'b1;
                  err_code_q  <= ERR_RESTART;
               end else if (pos_s == exp_pos_s) begin
                  idx_q       <= pos_s;
                  idx_valid_q <= 1'b1;
                  prev_q      <= pos_s;
                  if (prev_q == IDX_W'(N_STEPS - 1)) begin
                     round_done_q <= 1'b1;
                     round_cnt_q  <= round_cnt_q + RND_W'(1);
                  end else begin
                     round_done_q <= 1'b0;
                  end
               end else begin
                  // Covers skips and a step held for two samples.
                  state_q     <= FAULT;
                  idx_valid_q <= 1'b0;
                  err_q       <= 1'b1;
                  err_code_q  <= ERR_ORDER;
               end
            end
            FAULT: begin
               idx_valid_q <= 1'b0;
               if (bus.clr_err) begin
                  state_q    <= INIT;
                  err_q      <= 1'b0;
                  err_code_q <= ERR_NONE;
                  prev_q     <= '0;
               end else begin
                  err_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= INIT;
               idx_valid_q <= 1'b0;
               prev_q      <= '0;
            end
         endcase
      end
   end

   assign bus.idx        = idx_q;
   assign bus.idx_valid  = idx_valid_q;
   assign bus.round_done = round_done_q;
   assign bus.round_cnt  = round_cnt_q;
   assign bus.err        = err_q;
   assign bus.err_code   = err_code_q;

endmodule

// File: tb/tb_step_onehot_monitor.sv
// Self-checking bench for step_onehot_monitor: a behavioural reference
// model predicts each cycle's outputs into a scoreboard queue, which is
// popped and compared after the DUT's clock edge.
module tb_step_onehot_monitor;

   logic clk;
   logic rst;

   step_onehot_monitor_if bus ();

   step_onehot_monitor dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total;
   int bad;

   // Packed expected outputs: {idx, idx_valid, round_done, round_cnt, err, err_code}.
   logic [16:0] sb_q[$];

   // Reference model state (0 = waiting for start, 1 = running, 2 = faulted).
   int m_state;
   int m_prev;
   int m_idx;
   int m_valid;
   int m_rd;
   int m_cnt;
   int m_err;
   int m_code;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [16:0] dut_pack();
      return {bus.idx, bus.idx_valid, bus.round_done, bus.round_cnt, bus.err, bus.err_code};
   endfunction

   task automatic model_reset();
      m_state = 0; m_prev = 0; m_idx = 0; m_valid = 0;
      m_rd = 0; m_cnt = 0; m_err = 0; m_code = 0;
   endtask

   task automatic model_fault(input int code);
      m_state = 2; m_valid = 0; m_err = 1; m_code = code;
   endtask

   // Advance the reference model by one sample and push its prediction.
   task automatic model_step(input logic [8:0] step, input logic clr);
      int ones;
      int p;
      int e;
      ones = $countones(step);
      p = 0;
      for (int i = 0; i < 9; i++) if (step[i]) p = i;
      e = (m_prev == 0 || m_prev == 8) ? 1 : m_prev + 1;
      m_rd = 0;
      if (m_state == 0) begin
         if (step == 9'h001) begin
            m_idx = 0; m_valid = 0;
         end else if (step == 9'h002) begin
            m_state = 1; m_idx = 1; m_valid = 1; m_prev = 1;
         end else if (ones != 1) model_fault(1);
         else model_fault(2);
      end else if (m_state == 1) begin
         if (clr) begin
            m_state = 0; m_valid = 0; m_prev = 0;
         end else if (ones != 1) model_fault(1);
         else if (p == 0) model_fault(3);
         else if (p == e) begin
            m_idx = p; m_valid = 1;
            if (m_prev == 8) begin
               m_rd = 1; m_cnt = (m_cnt + 1) % 256;
            end
            m_prev = p;
         end else model_fault(2);
      end else begin
         if (clr) begin
            m_state = 0; m_err = 0; m_code = 0; m_prev = 0;
         end
      end
      sb_q.push_back({4'(m_idx), 1'(m_valid), 1'(m_rd), 8'(m_cnt), 1'(m_err), 2'(m_code)});
   endtask

   // Drive one sample, let the DUT clock it, then compare against the scoreboard.
   task automatic cycle(input logic [8:0] step, input logic clr);
      logic [16:0] exp_v;
      bus.step_in = step;
      bus.clr_err = clr;
      model_step(step, clr);
      @(posedge clk);
      #1;
      exp_v = sb_q.pop_front();
      check_eq("cycle", 32'(dut_pack()), 32'(exp_v));
   endtask

   task automatic run_round();
      for (int b = 2; b <= 8; b++) cycle(9'(1 << b), 1'b0);
      cycle(9'h002, 1'b0);
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1;
      bus.step_in = 9'h000;
      bus.clr_err = 1'b0;
      model_reset();
      #12;
      check_eq("reset_outputs", 32'(dut_pack()), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Start code held, then one full legal round and the wrap.
      for (int i = 0; i < 3; i++) cycle(9'h001, 1'b0);
      cycle(9'h002, 1'b0);
      check_eq("first_valid", 32'(bus.idx_valid), 32'd1);
      for (int b = 2; b <= 8; b++) cycle(9'(1 << b), 1'b0);
      cycle(9'h002, 1'b0);
      check_eq("wrap_pulse", 32'(bus.round_done), 32'd1);
      check_eq("round_cnt_1", 32'(bus.round_cnt), 32'd1);

      // Round counter rolls over to zero without raising a fault.
      for (int r = 0; r < 255; r++) run_round();
      check_eq("round_cnt_wrap", 32'(bus.round_cnt), 32'd0);
      check_eq("no_err_after_wrap", 32'(bus.err), 32'd0);

      // Two bits set while running, then a start code must not overwrite the cause.
      cycle(9'h004, 1'b0);
      cycle(9'h006, 1'b0);
      check_eq("multi_bit_code", 32'(bus.err_code), 32'd1);
      cycle(9'h001, 1'b0);
      check_eq("sticky_code", 32'(bus.err_code), 32'd1);
      check_eq("idx_held", 32'(bus.idx), 32'd2);
      cycle(9'h001, 1'b1);
      cycle(9'h002, 1'b0);

      // Stall: the same legal step sampled twice.
      cycle(9'h004, 1'b0);
      cycle(9'h008, 1'b0);
      cycle(9'h010, 1'b0);
      cycle(9'h010, 1'b0);
      check_eq("stall_code", 32'(bus.err_code), 32'd2);
      cycle(9'h000, 1'b1);
      cycle(9'h000, 1'b0);
      check_eq("zero_in_init_code", 32'(bus.err_code), 32'd1);
      cycle(9'h001, 1'b1);
      cycle(9'h002, 1'b0);

      // Restart code while running, clear on a bad step, then that step judged fresh.
      cycle(9'h004, 1'b0);
      cycle(9'h001, 1'b0);
      check_eq("restart_code", 32'(bus.err_code), 32'd3);
      cycle(9'h020, 1'b1);
      check_eq("cleared_err", 32'(bus.err), 32'd0);
      cycle(9'h020, 1'b0);
      check_eq("fresh_order_code", 32'(bus.err_code), 32'd2);
      cycle(9'h001, 1'b1);

      // Clear while running forces re-sync: a mid-cycle step is now out of order.
      cycle(9'h002, 1'b0);
      cycle(9'h004, 1'b0);
      cycle(9'h008, 1'b1);
      check_eq("run_clr_valid", 32'(bus.idx_valid), 32'd0);
      cycle(9'h010, 1'b0);
      check_eq("resync_code", 32'(bus.err_code), 32'd2);
      cycle(9'h001, 1'b1);

      // Build up five rounds, then reset asynchronously in mid-cycle.
      cycle(9'h002, 1'b0);
      for (int r = 0; r < 5; r++) run_round();
      check_eq("round_cnt_5", 32'(bus.round_cnt), 32'd5);
      cycle(9'h004, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check_eq("async_reset", 32'(dut_pack()), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cycle(9'h001, 1'b0);
      cycle(9'h002, 1'b0);
      check_eq("resume_valid", 32'(bus.idx_valid), 32'd1);
      run_round();
      check_eq("count_from_zero", 32'(bus.round_cnt), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog so the run always ends on its own.
   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule

// File: doc/step_onehot_monitor.md
Name: step_onehot_monitor

Overview:
- Receive-side companion of the 9-bit one-hot step sequencer.
- Samples the step vector every clock and checks that it is legal one-hot.
- Checks the required order: start code (bit 0) after reset, then bit 1 to bit 8, then back to bit 1.
- Outputs the binary step index, a round-complete strobe, a wrapping round counter, and a sticky fault flag with a cause code; downstream logic and debug pins use these.

Parameters:
- N_STEPS, 9, width of the one-hot step vector; bit 0 is the reset/start code and bits 1..N_STEPS-1 form the running cycle.
- IDX_W, 4, width of the binary index; must satisfy 2**IDX_W >= N_STEPS.
- RND_W, 8, width of the round counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- step_in  input  N_STEPS  one-hot step vector, synchronous to clk
- clr_err  input  1  synchronous fault clear; returns the block to INIT
- idx  output  IDX_W  binary position of the set bit in step_in
- idx_valid  output  1  idx reflects a legal, in-order step
- round_done  output  1  one-cycle pulse on each wrap from bit N_STEPS-1 to bit 1
- round_cnt  output  RND_W  count of completed rounds, wraps modulo 2**RND_W
- err  output  1  sticky fault flag
- err_code  output  2  cause of the first fault: 00 none, 01 not one-hot, 10 out-of-order or stall, 11 start code seen in RUN

Behaviour:
- Reset values: idx=0, idx_valid=0, round_done=0, round_cnt=0, err=0, err_code=00, state=INIT, prev=0.
- All outputs are registered. Decisions use step_in as sampled at edge k; the result appears after edge k, with 1-cycle latency.
- Combinational classification of step_in:
  - onehot: exactly one bit set.
  - pos: index of the set bit.
  - expected next after prev: bit 1 if prev is bit 0 or bit N_STEPS-1, otherwise bit prev+1.
- State INIT (waiting for the sequencer start):
  - step_in == bit 0: stay in INIT; idx=0, idx_valid=0.
  - step_in == bit 1: go to RUN; idx=1, idx_valid=1; prev=1.
  - Not one-hot: go to FAULT with code 01.
  - Any other one-hot value: go to FAULT with code 10.
- State RUN:
  - step_in == expected: stay in RUN; idx=pos, idx_valid=1; prev=pos.
  - If prev was N_STEPS-1 and step_in is bit 1: round_done=1 for exactly one cycle and round_cnt increments, wrapping from max to 0 with no flag.
  - Not one-hot (zero or multiple bits): go to FAULT with code 01.
  - step_in == bit 0: go to FAULT with code 11.
  - Other one-hot value, including the same value held for two samples (stall): go to FAULT with code 10.
- State FAULT:
  - err=1 and idx_valid=0. idx holds its last valid value. round_cnt holds.
  - err_code is captured on entry only; later faults do not overwrite it.
  - clr_err=1: next state is INIT with err=0 and err_code=00; round_cnt is kept; prev=0.
- clr_err outside FAULT:
  - In INIT it has no effect.
  - In RUN it forces INIT, so the monitor must re-sync to a start code or to bit 1.
- clr_err asserted on the same edge as a new fault condition: clr_err wins and the block goes to INIT. step_in is evaluated fresh on the next edge.
- Reset asserted mid-operation clears everything immediately, asynchronously. Deassertion takes effect on the next clk edge.
- Priority within one edge: rst > clr_err > fault detection > normal tracking.
- round_done is never asserted in the same cycle as err=1.

Decomposition:
- Shared package: state encoding constants (INIT, RUN, FAULT), err_code constants (ERR_NONE, ERR_NOT_ONEHOT, ERR_ORDER, ERR_RESTART), and the default N_STEPS=9.
- One natural sub-module, onehot_to_index: purely combinational. Outputs pos (IDX_W bits) and an onehot flag; the same encoder can serve other one-hot buses.
- The FSM, prev register and round counter live in the top module.

Test Plan:
- Reset, then step_in=0x001 for 3 cycles, then the legal sequence 0x002..0x100 and back to 0x002 -> idx_valid=1 from the first 0x002. idx runs 1..8,1. round_done pulses once, one cycle after 0x002 follows 0x100. round_cnt=1.
- Run 256 full rounds with RND_W=8 -> round_cnt wraps to 0. err stays 0 throughout.
- In RUN, inject step_in=0x006 (two bits) -> next cycle err=1, err_code=01, idx_valid=0. Then inject 0x001 -> err_code stays 01.
- In RUN at idx=3, drive 0x010 and then 0x010 again (stall) -> err=1, err_code=10.
- In RUN, drive 0x001 -> err_code=11. Then clr_err=1 while step_in=0x020 -> INIT, err=0, round_cnt unchanged. The next sample, 0x020, gives err_code=10.
- Assert rst asynchronously mid-cycle during RUN with round_cnt=5 -> all outputs 0 immediately. After release, 0x001 followed by 0x002 resumes with round_cnt counting from 0.
